// File: rtl/fma9_operand_loader.sv
// fma9_operand_loader: ping-pong loader of 19-word A/B/C FMA jobs from a serial word stream
module fma9_operand_loader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [1:0]       rnd_in,
  output logic [WIDTH-1:0] A1,
  output logic [WIDTH-1:0] A2,
  output logic [WIDTH-1:0] A3,
  output logic [WIDTH-1:0] A4,
  output logic [WIDTH-1:0] A5,
  output logic [WIDTH-1:0] A6,
  output logic [WIDTH-1:0] A7,
  output logic [WIDTH-1:0] A8,
  output logic [WIDTH-1:0] A9,
  output logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] B2,
  output logic [WIDTH-1:0] B3,
  output logic [WIDTH-1:0] B4,
  output logic [WIDTH-1:0] B5,
  output logic [WIDTH-1:0] B6,
  output logic [WIDTH-1:0] B7,
  output logic [WIDTH-1:0] B8,
  output logic [WIDTH-1:0] B9,
  output logic [WIDTH-1:0] C,
  output logic [1:0]       rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  input  logic             clr_err
);
  logic [WIDTH-1:0] mem [2][19];
  logic [1:0]       rnd_b [2];
  logic [1:0]       full;
  logic             wr_bank, rd_bank;
  logic [4:0]       wcnt;
  logic             acc, last_slot, done, bad, drain;
  assign in_ready  = ~full[wr_bank];
  assign acc       = in_valid & in_ready;
  assign last_slot = wcnt == 5'd18;
  assign done      = acc & last_slot & in_last;
  // in_last disagreeing with the slot position is a framing error; the partial job is dropped
  assign bad       = acc & (last_slot ^ in_last);
  assign out_valid = full[rd_bank];
  assign drain     = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        rnd_b[b] <= '0;
        for (int i = 0; i < 19; i++) mem[b][i] <= '0;
      end
    end else begin
      if (acc) begin
        mem[wr_bank][wcnt] <= in_data;
        if (wcnt == 5'd0) rnd_b[wr_bank] <= rnd_in;
        wcnt <= (done | bad) ? 5'd0 : wcnt + 5'd1;
      end
      if (done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      // a fill only targets a non-full bank and a drain a full one, so they never collide
      if (drain) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      frame_err <= bad | (frame_err & ~clr_err);
    end
  end
  assign A1  = mem[rd_bank][0];
  assign A2  = mem[rd_bank][1];
  assign A3  = mem[rd_bank][2];
  assign A4  = mem[rd_bank][3];
  assign A5  = mem[rd_bank][4];
  assign A6  = mem[rd_bank][5];
  assign A7  = mem[rd_bank][6];
  assign A8  = mem[rd_bank][7];
  assign A9  = mem[rd_bank][8];
  assign B1  = mem[rd_bank][9];
  assign B2  = mem[rd_bank][10];
  assign B3  = mem[rd_bank][11];
  assign B4  = mem[rd_bank][12];
  assign B5  = mem[rd_bank][13];
  assign B6  = mem[rd_bank][14];
  assign B7  = mem[rd_bank][15];
  assign B8  = mem[rd_bank][16];
  assign B9  = mem[rd_bank][17];
  assign C   = mem[rd_bank][18];
  assign rnd = rnd_b[rd_bank];
endmodule

// File: tb/tb_fma9_operand_loader.sv
// tb_fma9_operand_loader: directed checks of framing, ping-pong banking, backpressure and reset
module tb_fma9_operand_loader;
  logic        clk = 0, rst = 0;
  logic [31:0] in_data = 0;
  logic        in_valid = 0, in_last = 0, out_ready = 0, clr_err = 0;
  logic [1:0]  rnd_in = 0, rnd;
  logic        in_ready, out_valid, frame_err;
  logic [31:0] A1, A2, A3, A4, A5, A6, A7, A8, A9;
  logic [31:0] B1, B2, B3, B4, B5, B6, B7, B8, B9, C;
  int vecs = 0, errs = 0, stalls = 0, cyc = 0;
  logic [31:0] xq[$];
  int          tq[$];

  fma9_operand_loader #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .rnd_in(rnd_in),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8), .A9(A9),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8), .B9(B9),
    .C(C), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && out_valid && out_ready) begin
      xq.push_back(A1);
      tq.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] w(input int j, input int i);
    return 32'h3F800000 | 32'(j << 8) | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_valid = 1;
    while (!in_ready && n < 100) begin tick(1); n++; stalls++; end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    tick(1);
  endtask

  task automatic job(input int j);
    for (int i = 0; i < 19; i++) send(w(j, i), i == 18);
  endtask

  task automatic idle();
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    // reset state
    tick(2);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_A1", A1, 0);
    check("rst_C", C, 0);
    check("rst_rnd", {30'd0, rnd}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    rst = 1;
    tick(1);
    // single job, held stable
    rnd_in = 2'b01;
    for (int i = 0; i < 18; i++) send(w(0, i), 0);
    check("j0_not_yet_valid", {31'd0, out_valid}, 0);
    send(w(0, 18), 1);
    idle();
    check("j0_out_valid", {31'd0, out_valid}, 1);
    check("j0_A1", A1, w(0, 0));
    check("j0_A9", A9, w(0, 8));
    check("j0_B1", B1, w(0, 9));
    check("j0_B9", B9, w(0, 17));
    check("j0_C", C, w(0, 18));
    check("j0_rnd", {30'd0, rnd}, 1);
    tick(3);
    check("j0_hold_valid", {31'd0, out_valid}, 1);
    check("j0_hold_A1", A1, w(0, 0));
    check("j0_hold_C", C, w(0, 18));
    out_ready = 1; tick(1); out_ready = 0;
    check("j0_drained", {31'd0, out_valid}, 0);
    // backpressure: both banks full stalls word 39
    rnd_in = 2'b10;
    job(1);
    rnd_in = 2'b11;
    job(2);
    check("bp_in_ready_low", {31'd0, in_ready}, 0);
    check("bp_A1_job1", A1, w(1, 0));
    check("bp_rnd_job1", {30'd0, rnd}, 2);
    rnd_in = 2'b00;
    in_data = w(3, 0); in_last = 0; in_valid = 1;
    tick(3);
    check("bp_still_stalled", {31'd0, in_ready}, 0);
    check("bp_still_job1", A1, w(1, 0));
    out_ready = 1; tick(1); out_ready = 0;
    check("bp_A1_job2", A1, w(2, 0));
    check("bp_rnd_job2", {30'd0, rnd}, 3);
    check("bp_in_ready_back", {31'd0, in_ready}, 1);
    job(3);
    idle();
    out_ready = 1; tick(1); out_ready = 0;
    check("bp_A1_job3", A1, w(3, 0));
    check("bp_C_job3", C, w(3, 18));
    check("bp_rnd_job3", {30'd0, rnd}, 0);
    out_ready = 1; tick(1); out_ready = 0;
    check("bp_all_drained", {31'd0, out_valid}, 0);
    // early in_last on word 5
    for (int i = 0; i < 5; i++) send(w(9, i), i == 4);
    idle();
    check("early_frame_err", {31'd0, frame_err}, 1);
    check("early_no_valid", {31'd0, out_valid}, 0);
    rnd_in = 2'b01;
    job(4);
    idle();
    check("early_next_valid", {31'd0, out_valid}, 1);
    check("early_next_A1", A1, w(4, 0));
    check("early_next_C", C, w(4, 18));
    check("early_err_sticky", {31'd0, frame_err}, 1);
    clr_err = 1; tick(1); clr_err = 0;
    check("clr_err", {31'd0, frame_err}, 0);
    out_ready = 1; tick(1); out_ready = 0;
    // missing in_last on word 19
    for (int i = 0; i < 19; i++) send(w(8, i), 0);
    idle();
    check("late_frame_err", {31'd0, frame_err}, 1);
    check("late_no_valid", {31'd0, out_valid}, 0);
    job(5);
    idle();
    check("late_next_A1", A1, w(5, 0));
    check("late_next_B5", B5, w(5, 13));
    out_ready = 1; tick(1); out_ready = 0;
    // a new error in the same cycle as clr_err wins
    clr_err = 1;
    send(w(7, 0), 1);
    clr_err = 0;
    idle();
    check("set_wins_clr", {31'd0, frame_err}, 1);
    clr_err = 1; tick(1); clr_err = 0;
    check("clr_after_set", {31'd0, frame_err}, 0);
    // continuous streaming of 10 jobs
    xq.delete(); tq.delete();
    stalls = 0;
    out_ready = 1;
    for (int j = 10; j < 20; j++) job(j);
    idle();
    tick(3);
    out_ready = 0;
    check("stream_no_stalls", 32'(stalls), 0);
    check("stream_count", 32'(xq.size()), 10);
    for (int k = 0; k < 10 && k < xq.size(); k++) begin
      check($sformatf("stream_A1_%0d", k), xq[k], w(10 + k, 0));
      if (k > 0) check($sformatf("stream_gap_%0d", k), 32'(tq[k] - tq[k-1]), 19);
    end
    // asynchronous reset mid-job
    for (int i = 0; i < 10; i++) send(w(20, i), 0);
    idle();
    #2 rst = 0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_A1", A1, 0);
    check("mid_rst_rnd", {30'd0, rnd}, 0);
    tick(1);
    rst = 1;
    rnd_in = 2'b10;
    job(21);
    idle();
    check("post_rst_valid", {31'd0, out_valid}, 1);
    check("post_rst_A1", A1, w(21, 0));
    check("post_rst_C", C, w(21, 18));
    check("post_rst_rnd", {30'd0, rnd}, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fma9_operand_loader.md
FMA9_OPERAND_LOADER -- requirements
Module: fma9_operand_loader

Interface
REQ-001 Parameter WIDTH, default 32, operand word width (IEEE-754 single).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  WIDTH  serial operand word.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_last  input  1  marks the final word of a job.
REQ-007 in_ready  output  1  loader accepts a word this cycle.
REQ-008 rnd_in  input  2  rounding mode, captured per job.
REQ-009 A1..A9  output  WIDTH each  multiplicand operands to fpfma_pipeline.
REQ-010 B1..B9  output  WIDTH each  multiplier operands to fpfma_pipeline.
REQ-011 C  output  WIDTH  addend operand.
REQ-012 rnd  output  2  rounding mode of the presented job.
REQ-013 out_valid  output  1  complete job presented on A/B/C/rnd.
REQ-014 out_ready  input  1  downstream consumes the presented job.
REQ-015 frame_err  output  1  sticky framing-error flag.
REQ-016 clr_err  input  1  synchronous clear of frame_err.

Function
REQ-017 Job = 19 words in fixed order: A1..A9, B1..B9, C (word index 0..18).
REQ-018 Two operand banks (ping-pong); each bank holds 19 words, a 2-bit rnd field and a full flag.
REQ-019 Write pointer wr_bank selects the filling bank; 5-bit counter wcnt (0..18) selects the word slot.
REQ-020 in_ready = NOT full[wr_bank]; word accepted when in_valid AND in_ready.
REQ-021 On accept, in_data is written to slot wcnt of bank wr_bank; at wcnt=0, rnd_in is also captured into that bank.
REQ-022 Accept with wcnt<18 and in_last=0: wcnt increments.
REQ-023 Accept with wcnt=18 and in_last=1: full[wr_bank] set, wr_bank toggles, wcnt returns to 0.
REQ-024 Accept with wcnt<18 and in_last=1, or wcnt=18 and in_last=0: frame_err set, bank not marked full, wcnt returns to 0, wr_bank unchanged (partial job discarded).
REQ-025 Read pointer rd_bank; out_valid = full[rd_bank].
REQ-026 A1..C and rnd are driven from bank rd_bank; they hold stable while out_valid=1 and out_ready=0.
REQ-027 out_valid AND out_ready: full[rd_bank] cleared, rd_bank toggles on the same edge.
REQ-028 Latency: out_valid asserts the cycle after the 19th word is accepted, if the bank is at the read pointer.
REQ-029 Fill completion on one bank and drain of the other in the same cycle are both performed.
REQ-030 Both banks full: in_ready=0; no word is written until a drain occurs.
REQ-031 With continuous input and out_ready=1, sustained throughput is one job per 19 cycles with no input bubbles.
REQ-032 clr_err=1 clears frame_err unless a new framing error occurs in the same cycle (set wins).
REQ-033 out_ready while out_valid=0 has no effect.

Reset
REQ-034 rst=0 asynchronously clears: wcnt=0, wr_bank=0, rd_bank=0, both full flags=0, frame_err=0.
REQ-035 During reset: out_valid=0, in_ready=1, A1..C=0, rnd=0; bank contents reset to 0.
REQ-036 Reset mid-job discards the partial job; the first word after release is word index 0.

Verification
REQ-037 Reset, then 19 words 0x3F800000..(index in low bits), in_last on word 19, rnd_in=01, out_ready=0 -> out_valid=1 the next cycle, A1=word0, C=word18, rnd=01, held stable.
REQ-038 Feed 3 jobs back-to-back with out_ready=0 -> in_ready drops after the 38th word; word 39 is stalled until one out_ready pulse, then accepted.
REQ-039 in_last on word 5 -> frame_err=1, out_valid stays 0; next 19-word job is presented correctly; clr_err=1 -> frame_err=0 next cycle.
REQ-040 19 words with in_last=0 on word 19 -> frame_err=1, job discarded, wcnt=0.
REQ-041 Continuous streaming of 10 jobs with out_ready=1 -> in_ready constantly 1, 10 out_valid transfers in job order, spacing 19 cycles.
REQ-042 Assert rst=0 after word 10 of a job -> outputs 0 immediately; after release a full 19-word job is presented with word 0 in A1.
